// File: rtl/nice_dec_pkg.sv
// Shared definitions for the NICE custom-0 decoder:
// opcode and funct7 encodings, the ICB word size and the sequencer state type.
package nice_dec_pkg;

    localparam logic [6:0] OPC_CUSTOM0   = 7'b0001011;

    localparam logic [6:0] F7_CFG_WR     = 7'h01;
    localparam logic [6:0] F7_CFG_RD     = 7'h02;
    localparam logic [6:0] F7_MEM_LD     = 7'h03;
    localparam logic [6:0] F7_MEM_ST     = 7'h04;

    // log2 of the access size in bytes; the word stride is derived from it.
    localparam logic [1:0] ICB_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD   = 2'd1,
        ST   = 2'd2,
        RSP  = 2'd3
    } state_e;

endpackage

// File: rtl/nice_icb_seq.sv
// ICB word sequencer shared by memory loads and stores. It tracks the next
// word address, how many commands were issued and how many responses came
// back, and allows only one command in flight at a time.
module nice_icb_seq
    import nice_dec_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WORDS  = 4,
    parameter int CNT_WIDTH  = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  cmd_fire,
    input  logic                  rsp_fire,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  can_issue,
    output logic                  last_rsp
);

    // Byte stride between consecutive words.
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(1) << ICB_SIZE_WORD;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_WIDTH-1:0]  issued_reg;
    logic [CNT_WIDTH-1:0]  rcvd_reg;
    logic                  outstanding_reg;

    // Address/counter/outstanding tracking; the address only moves on a
    // command handshake, so stalls never skip a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg        <= '0;
            issued_reg      <= '0;
            rcvd_reg        <= '0;
            outstanding_reg <= 1'b0;
        end else if (start) begin
            addr_reg        <= base_addr;
            issued_reg      <= '0;
            rcvd_reg        <= '0;
            outstanding_reg <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_reg   <= addr_reg + ADDR_STEP;
                issued_reg <= issued_reg + CNT_WIDTH'(1);
            end
            if (rsp_fire) begin
                rcvd_reg <= rcvd_reg + CNT_WIDTH'(1);
            end
            if (cmd_fire) begin
                outstanding_reg <= 1'b1;
            end else if (rsp_fire) begin
                outstanding_reg <= 1'b0;
            end
        end
    end

    assign cmd_addr  = addr_reg;
    assign can_issue = !outstanding_reg && (issued_reg < num_words);
    assign last_rsp  = rsp_fire && ((rcvd_reg + CNT_WIDTH'(1)) == num_words);

endmodule

// File: rtl/nice_inst_decoder.sv
// NICE custom-0 decoder and sequencer: config register writes/reads, ICB
// memory loads streamed into the command FIFO and ICB memory stores fed
// from the response width converter. One NICE response per request.
// Optional: define NICE_CFG_RD_EN to make funct7 0x02 (config read) legal;
// without it that encoding is answered as an illegal instruction.
module nice_inst_decoder
    import nice_dec_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 32,
    parameter int INPUT_INST_WIDTH  = 32,
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int OUTPUT_ADDR_WIDTH = 32,
    parameter int CONFIG_ENTRY0     = 32,
    parameter int FETCH_MEM_WORD0   = 4,
    parameter int WRITE_MEM_WORD0   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          nice_active,
    input  logic                          nice_req_valid,
    output logic                          nice_req_ready,
    input  logic [INPUT_INST_WIDTH-1:0]   nice_req_inst,
    input  logic [INPUT_DATA_WIDTH-1:0]   nice_req_rs1,
    input  logic [INPUT_DATA_WIDTH-1:0]   nice_req_rs2,
    output logic                          nice_rsp_valid,
    input  logic                          nice_rsp_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0]  nice_rsp_rdat,
    output logic                          nice_rsp_err,
    output logic                          nice_icb_cmd_valid,
    input  logic                          nice_icb_cmd_ready,
    output logic [OUTPUT_ADDR_WIDTH-1:0]  nice_icb_cmd_addr,
    output logic                          nice_icb_cmd_read,
    output logic [OUTPUT_DATA_WIDTH-1:0]  nice_icb_cmd_wdata,
    output logic [1:0]                    nice_icb_cmd_size,
    output logic                          nice_mem_holdup,
    input  logic                          nice_icb_rsp_valid,
    output logic                          nice_icb_rsp_ready,
    input  logic [INPUT_DATA_WIDTH-1:0]   nice_icb_rsp_rdata,
    input  logic                          nice_icb_rsp_err,
    output logic                          id_cmd_valid0,
    input  logic                          id_cmd_ready0,
    output logic [OUTPUT_DATA_WIDTH-1:0]  id_cmd_wdata0,
    input  logic                          id_rsp_valid0,
    output logic                          id_rsp_ready0,
    input  logic [INPUT_DATA_WIDTH-1:0]   id_rsp_rdata0,
    output logic [OUTPUT_DATA_WIDTH-1:0]  config_reg0 [CONFIG_ENTRY0]
);

    localparam int IDX_W     = (CONFIG_ENTRY0 > 1) ? $clog2(CONFIG_ENTRY0) : 1;
    localparam int MAX_WORDS = (FETCH_MEM_WORD0 > WRITE_MEM_WORD0) ? FETCH_MEM_WORD0 : WRITE_MEM_WORD0;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    state_e                         state_reg, state_next;
    logic [OUTPUT_DATA_WIDTH-1:0]   rsp_rdat_reg, rsp_rdat_next;
    logic                           rsp_err_reg, rsp_err_next;
    logic [OUTPUT_DATA_WIDTH-1:0]   config_reg [CONFIG_ENTRY0];

    logic [6:0]                     opcode;
    logic [6:0]                     funct7;
    logic [IDX_W-1:0]               cfg_idx;
    logic                           idx_ok;
    logic                           cfg_wr_en;
    logic                           seq_start;
    logic                           in_ld, in_st;
    logic                           cmd_fire, rsp_fire;
    logic                           can_issue, last_rsp;
    logic [OUTPUT_ADDR_WIDTH-1:0]   seq_addr;
    logic [CNT_W-1:0]               seq_words;
    logic                           unused_inst_bits;

    assign opcode           = nice_req_inst[6:0];
    assign funct7           = nice_req_inst[31:25];
    assign cfg_idx          = nice_req_rs1[IDX_W-1:0];
    assign idx_ok           = nice_req_rs1 < INPUT_DATA_WIDTH'(CONFIG_ENTRY0);
    assign unused_inst_bits = ^nice_req_inst[24:7];

    assign in_ld = (state_reg == LD);
    assign in_st = (state_reg == ST);

    // Handshake outputs: everything on the ICB and id_* sides is quiet
    // unless a load or store is running.
    assign nice_req_ready     = (state_reg == IDLE);
    assign nice_rsp_valid     = (state_reg == RSP);
    assign nice_rsp_rdat      = rsp_rdat_reg;
    assign nice_rsp_err       = rsp_err_reg;
    assign nice_active        = (state_reg != IDLE);
    assign nice_mem_holdup    = in_ld || in_st;
    assign nice_icb_cmd_size  = ICB_SIZE_WORD;
    assign nice_icb_cmd_valid = (in_ld && can_issue) || (in_st && can_issue && id_rsp_valid0);
    assign nice_icb_cmd_read  = in_ld;
    assign nice_icb_cmd_addr  = (in_ld || in_st) ? seq_addr : '0;
    assign nice_icb_cmd_wdata = in_st ? OUTPUT_DATA_WIDTH'(id_rsp_rdata0) : '0;
    assign nice_icb_rsp_ready = (in_ld && id_cmd_ready0) || in_st;
    assign id_cmd_valid0      = in_ld && nice_icb_rsp_valid;
    assign id_cmd_wdata0      = in_ld ? OUTPUT_DATA_WIDTH'(nice_icb_rsp_rdata) : '0;
    assign id_rsp_ready0      = in_st && can_issue && id_rsp_valid0 && nice_icb_cmd_ready;

    assign cmd_fire  = nice_icb_cmd_valid && nice_icb_cmd_ready;
    assign rsp_fire  = nice_icb_rsp_valid && nice_icb_rsp_ready;
    assign seq_words = in_st ? CNT_W'(WRITE_MEM_WORD0) : CNT_W'(FETCH_MEM_WORD0);

    nice_icb_seq #(
        .ADDR_WIDTH (OUTPUT_ADDR_WIDTH),
        .MAX_WORDS  (MAX_WORDS),
        .CNT_WIDTH  (CNT_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (seq_start),
        .base_addr  (OUTPUT_ADDR_WIDTH'(nice_req_rs1)),
        .num_words  (seq_words),
        .cmd_fire   (cmd_fire),
        .rsp_fire   (rsp_fire),
        .cmd_addr   (seq_addr),
        .can_issue  (can_issue),
        .last_rsp   (last_rsp)
    );

    // Decode on accept, track memory-op completion and sticky error, and
    // release the response.
    always_comb begin
        state_next    = state_reg;
        rsp_rdat_next = rsp_rdat_reg;
        rsp_err_next  = rsp_err_reg;
        cfg_wr_en     = 1'b0;
        seq_start     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (nice_req_valid) begin
                    state_next    = RSP;
                    rsp_rdat_next = '0;
                    rsp_err_next  = 1'b1;
                    if (opcode == OPC_CUSTOM0) begin
                        case (funct7)
                            F7_CFG_WR: begin
                                rsp_err_next = !idx_ok;
                                cfg_wr_en    = idx_ok;
                            end
`ifdef NICE_CFG_RD_EN
                            F7_CFG_RD: begin
                                rsp_err_next  = !idx_ok;
                                rsp_rdat_next = idx_ok ? config_reg[cfg_idx] : '0;
                            end
`endif
                            F7_MEM_LD: begin
                                state_next   = LD;
                                rsp_err_next = 1'b0;
                                seq_start    = 1'b1;
                            end
                            F7_MEM_ST: begin
                                state_next   = ST;
                                rsp_err_next = 1'b0;
                                seq_start    = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            LD, ST: begin
                if (rsp_fire && nice_icb_rsp_err) begin
                    rsp_err_next = 1'b1;
                end
                if (last_rsp) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (nice_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rsp_rdat_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rsp_rdat_reg <= rsp_rdat_next;
            rsp_err_reg  <= rsp_err_next;
        end
    end

    // Configuration register file, written on the accept edge of CFG_WR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CONFIG_ENTRY0; i++) begin
                config_reg[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            config_reg[cfg_idx] <= OUTPUT_DATA_WIDTH'(nice_req_rs2);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CONFIG_ENTRY0; gi++) begin : g_cfg_out
            assign config_reg0[gi] = config_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_nice_inst_decoder.sv
// Directed bench for nice_inst_decoder with scoreboard queues for NICE
// responses, ICB commands and command-FIFO pushes, plus an ICB memory model.
module tb_nice_inst_decoder;

    localparam int CE = 32;
    localparam logic [6:0] OPC = 7'b0001011;

    logic        clk = 1'b0;
    logic        rst;
    logic        nice_active;
    logic        nice_req_valid, nice_req_ready;
    logic [31:0] nice_req_inst, nice_req_rs1, nice_req_rs2;
    logic        nice_rsp_valid, nice_rsp_ready;
    logic [31:0] nice_rsp_rdat;
    logic        nice_rsp_err;
    logic        nice_icb_cmd_valid, nice_icb_cmd_ready;
    logic [31:0] nice_icb_cmd_addr;
    logic        nice_icb_cmd_read;
    logic [31:0] nice_icb_cmd_wdata;
    logic [1:0]  nice_icb_cmd_size;
    logic        nice_mem_holdup;
    logic        nice_icb_rsp_valid, nice_icb_rsp_ready;
    logic [31:0] nice_icb_rsp_rdata;
    logic        nice_icb_rsp_err;
    logic        id_cmd_valid0, id_cmd_ready0;
    logic [31:0] id_cmd_wdata0;
    logic        id_rsp_valid0, id_rsp_ready0;
    logic [31:0] id_rsp_rdata0;
    logic [31:0] config_reg0 [CE];

    always #5 clk = ~clk;

    nice_inst_decoder dut (
        .clk                (clk),
        .rst                (rst),
        .nice_active        (nice_active),
        .nice_req_valid     (nice_req_valid),
        .nice_req_ready     (nice_req_ready),
        .nice_req_inst      (nice_req_inst),
        .nice_req_rs1       (nice_req_rs1),
        .nice_req_rs2       (nice_req_rs2),
        .nice_rsp_valid     (nice_rsp_valid),
        .nice_rsp_ready     (nice_rsp_ready),
        .nice_rsp_rdat      (nice_rsp_rdat),
        .nice_rsp_err       (nice_rsp_err),
        .nice_icb_cmd_valid (nice_icb_cmd_valid),
        .nice_icb_cmd_ready (nice_icb_cmd_ready),
        .nice_icb_cmd_addr  (nice_icb_cmd_addr),
        .nice_icb_cmd_read  (nice_icb_cmd_read),
        .nice_icb_cmd_wdata (nice_icb_cmd_wdata),
        .nice_icb_cmd_size  (nice_icb_cmd_size),
        .nice_mem_holdup    (nice_mem_holdup),
        .nice_icb_rsp_valid (nice_icb_rsp_valid),
        .nice_icb_rsp_ready (nice_icb_rsp_ready),
        .nice_icb_rsp_rdata (nice_icb_rsp_rdata),
        .nice_icb_rsp_err   (nice_icb_rsp_err),
        .id_cmd_valid0      (id_cmd_valid0),
        .id_cmd_ready0      (id_cmd_ready0),
        .id_cmd_wdata0      (id_cmd_wdata0),
        .id_rsp_valid0      (id_rsp_valid0),
        .id_rsp_ready0      (id_rsp_ready0),
        .id_rsp_rdata0      (id_rsp_rdata0),
        .config_reg0        (config_reg0)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboards
    logic [31:0] exp_rdat_q [$];
    logic        exp_err_q  [$];
    logic [31:0] exp_addr_q [$];
    logic        exp_read_q [$];
    logic [31:0] exp_wdata_q[$];
    logic [31:0] exp_push_q [$];
    int          rsp_seen = 0;
    int          pop_cnt  = 0;

    // Driver state
    int          drv_mode = 0;   // 0 quiet, 1 load (toggle id_cmd_ready0), 2 store feed
    int          cyc_cnt  = 0;
    int          st_pos   = 0;
    logic        st_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] st_d [6] = '{32'hAAAAAAAA, 32'h0, 32'hBBBBBBBB, 32'h0, 32'hCCCCCCCC, 32'hDDDDDDDD};
    logic        req_acc  = 1'b0;
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [6:0] opc);
        return {f7, 18'd0, opc};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return 32'hAAAAAAAA;
            2'd1:    return 32'hBBBBBBBB;
            2'd2:    return 32'hCCCCCCCC;
            default: return 32'hDDDDDDDD;
        endcase
    endfunction

    // Response, FIFO-push and pop-count monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (nice_rsp_valid && nice_rsp_ready) begin
                if (exp_rdat_q.size() == 0) begin
                    total++; bad++;
                    $error("FAIL rsp_unexpected: observed rdat=%h expected none", nice_rsp_rdat);
                end else begin
                    chk("rsp_rdat", nice_rsp_rdat, exp_rdat_q.pop_front());
                    chk("rsp_err", 32'(nice_rsp_err), 32'(exp_err_q.pop_front()));
                end
                $display("rsp #%0d rdat=%h err=%0d", rsp_seen, nice_rsp_rdat, nice_rsp_err);
                rsp_seen++;
            end
            if (id_cmd_valid0 && id_cmd_ready0) begin
                if (exp_push_q.size() == 0) begin
                    total++; bad++;
                    $error("FAIL push_unexpected: observed=%h expected none", id_cmd_wdata0);
                end else begin
                    chk("push_data", id_cmd_wdata0, exp_push_q.pop_front());
                end
                $display("fifo push %h", id_cmd_wdata0);
            end
            if (id_rsp_ready0) pop_cnt++;
        end
    end

    // ICB memory model: one-cycle response latency, response held until taken
    initial begin : icb_mem
        logic r_taken, c_taken, c_read;
        logic [31:0] c_addr;
        nice_icb_cmd_ready = 1'b1;
        nice_icb_rsp_valid = 1'b0;
        nice_icb_rsp_rdata = 32'h0;
        nice_icb_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nice_icb_rsp_valid = 1'b0;
                continue;
            end
            r_taken = nice_icb_rsp_valid && nice_icb_rsp_ready;
            c_taken = nice_icb_cmd_valid && nice_icb_cmd_ready;
            c_addr  = nice_icb_cmd_addr;
            c_read  = nice_icb_cmd_read;
            if (c_taken) begin
                $display("icb cmd addr=%h read=%0d wdata=%h", c_addr, c_read, nice_icb_cmd_wdata);
                if (exp_addr_q.size() == 0) begin
                    total++; bad++;
                    $error("FAIL icb_unexpected: observed addr=%h expected none", c_addr);
                end else begin
                    chk("icb_addr", c_addr, exp_addr_q.pop_front());
                    chk("icb_read", 32'(c_read), 32'(exp_read_q.pop_front()));
                    chk("icb_size", 32'(nice_icb_cmd_size), 32'd2);
                    if (!c_read) chk("icb_wdata", nice_icb_cmd_wdata, exp_wdata_q.pop_front());
                    else void'(exp_wdata_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (r_taken) nice_icb_rsp_valid = 1'b0;
            if (c_taken && !rst) begin
                nice_icb_rsp_valid = 1'b1;
                nice_icb_rsp_rdata = c_read ? mem_word(c_addr) : 32'h0;
                nice_icb_rsp_err   = err_en && (c_addr == err_addr);
            end
        end
    end

    // One clock: observe at negedge, drive just after posedge
    task automatic step();
        @(negedge clk);
        req_acc = nice_req_valid && nice_req_ready;
        if (drv_mode == 2 && st_pos < 6) begin
            if (!st_v[st_pos] || (id_rsp_valid0 && id_rsp_ready0)) st_pos++;
        end
        @(posedge clk);
        #1;
        cyc_cnt++;
        id_cmd_ready0 = (drv_mode == 1) ? ((cyc_cnt / 2) % 2 == 1) : 1'b0;
        id_rsp_valid0 = (drv_mode == 2 && st_pos < 6) ? st_v[st_pos] : 1'b0;
        id_rsp_rdata0 = (drv_mode == 2 && st_pos < 6) ? st_d[st_pos] : 32'h0;
    endtask

    task automatic send_req(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
        int c = 0;
        nice_req_valid = 1'b1;
        nice_req_inst  = inst;
        nice_req_rs1   = rs1;
        nice_req_rs2   = rs2;
        req_acc = 1'b0;
        while (!req_acc && c < 50) begin
            step();
            c++;
        end
        chk("req_accepted", 32'(req_acc), 32'd1);
        nice_req_valid = 1'b0;
    endtask

    task automatic push_rsp(input logic [31:0] rdat, input logic err);
        exp_rdat_q.push_back(rdat);
        exp_err_q.push_back(err);
    endtask

    task automatic push_words(input logic [31:0] base, input logic rd);
        for (int k = 0; k < 4; k++) begin
            exp_addr_q.push_back(base + 32'(4 * k));
            exp_read_q.push_back(rd);
            exp_wdata_q.push_back(mem_word(base + 32'(4 * k)));
            if (rd) exp_push_q.push_back(mem_word(base + 32'(4 * k)));
        end
    endtask

    task automatic wait_rsp(input int target);
        int c = 0;
        while (rsp_seen < target && c < 300) begin
            step();
            c++;
        end
        chk("rsp_count", 32'(rsp_seen), 32'(target));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int pop0;
        int c;
        int nz;
        nice_req_valid = 0; nice_req_inst = 0; nice_req_rs1 = 0; nice_req_rs2 = 0;
        nice_rsp_ready = 1; id_cmd_ready0 = 0; id_rsp_valid0 = 0; id_rsp_rdata0 = 0;
        rst = 0;
        #2 rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", 32'(nice_active), 32'd0);
        chk("rst_rsp_valid", 32'(nice_rsp_valid), 32'd0);
        chk("rst_cmd_valid", 32'(nice_icb_cmd_valid), 32'd0);
        chk("rst_req_ready", 32'(nice_req_ready), 32'd1);
        chk("rst_cfg0", config_reg0[0], 32'h0);
        rst = 0;
        step();

        // CFG_WR idx 5
        push_rsp(32'h0, 1'b0);
        send_req(mk(7'h01, OPC), 32'd5, 32'h12345678);
        chk("cfg5_written", config_reg0[5], 32'h12345678);
        wait_rsp(1);

        // MEM_LD with id_cmd_ready0 toggling
        push_words(32'h8000_0000, 1'b1);
        push_rsp(32'h0, 1'b0);
        drv_mode = 1;
        send_req(mk(7'h03, OPC), 32'h8000_0000, 32'h0);
        chk("ld_holdup", 32'(nice_mem_holdup), 32'd1);
        wait_rsp(2);
        drv_mode = 0;
        chk("ld_cmds_left", 32'(exp_addr_q.size()), 32'd0);
        chk("ld_push_left", 32'(exp_push_q.size()), 32'd0);

        // MEM_ST with gaps in the feed
        push_words(32'h9000_0000, 1'b0);
        push_rsp(32'h0, 1'b0);
        st_pos = 0;
        pop0 = pop_cnt;
        drv_mode = 2;
        send_req(mk(7'h04, OPC), 32'h9000_0000, 32'h0);
        wait_rsp(3);
        drv_mode = 0;
        chk("st_pops", 32'(pop_cnt - pop0), 32'd4);
        chk("st_cmds_left", 32'(exp_addr_q.size()), 32'd0);

        // Wrong opcode with response back-pressure
        push_rsp(32'h0, 1'b1);
        nice_rsp_ready = 0;
        send_req(mk(7'h01, 7'b0101011), 32'd5, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(nice_rsp_valid), 32'd1);
            chk("stall_rdat", nice_rsp_rdat, 32'h0);
            chk("stall_err", 32'(nice_rsp_err), 32'd1);
        end
        nice_rsp_ready = 1;
        wait_rsp(4);
        chk("bad_opc_no_write", config_reg0[5], 32'h12345678);

        // Illegal funct7
        push_rsp(32'h0, 1'b1);
        send_req(mk(7'h7F, OPC), 32'd6, 32'h11111111);
        wait_rsp(5);
        chk("bad_f7_no_write", config_reg0[6], 32'h0);

        // Config read (legal only when the option is built in)
`ifdef NICE_CFG_RD_EN
        push_rsp(32'h12345678, 1'b0);
`else
        push_rsp(32'h0, 1'b1);
`endif
        send_req(mk(7'h02, OPC), 32'd5, 32'h0);
        wait_rsp(6);

        // Out-of-range CFG_WR
        push_rsp(32'h0, 1'b1);
        send_req(mk(7'h01, OPC), 32'd40, 32'hCAFEF00D);
        wait_rsp(7);
        chk("oor_no_write", config_reg0[8], 32'h0);

        // MEM_LD with an error on word 2
        push_words(32'h8000_0000, 1'b1);
        push_rsp(32'h0, 1'b1);
        err_en = 1; err_addr = 32'h8000_0008;
        drv_mode = 1;
        send_req(mk(7'h03, OPC), 32'h8000_0000, 32'h0);
        wait_rsp(8);
        drv_mode = 0; err_en = 0;
        chk("lderr_cmds_left", 32'(exp_addr_q.size()), 32'd0);
        chk("lderr_push_left", 32'(exp_push_q.size()), 32'd0);

        // Reset in the middle of MEM_ST after two words
        push_words(32'h9000_0000, 1'b0);
        push_rsp(32'h0, 1'b0);
        st_pos = 0;
        pop0 = pop_cnt;
        drv_mode = 2;
        send_req(mk(7'h04, OPC), 32'h9000_0000, 32'h0);
        c = 0;
        while ((pop_cnt - pop0) < 2 && c < 100) begin
            step();
            c++;
        end
        chk("pre_rst_pops", 32'(pop_cnt - pop0), 32'd2);
        rst = 1;
        drv_mode = 0;
        #2;
        chk("midrst_active", 32'(nice_active), 32'd0);
        chk("midrst_holdup", 32'(nice_mem_holdup), 32'd0);
        chk("midrst_cmd_valid", 32'(nice_icb_cmd_valid), 32'd0);
        step();
        step();
        exp_addr_q.delete(); exp_read_q.delete(); exp_wdata_q.delete();
        exp_push_q.delete(); exp_rdat_q.delete(); exp_err_q.delete();
        rst = 0;
        step();
        chk("post_rst_req_ready", 32'(nice_req_ready), 32'd1);
        chk("post_rst_holdup", 32'(nice_mem_holdup), 32'd0);
        nz = 0;
        for (int i = 0; i < CE; i++) if (config_reg0[i] !== 32'h0) nz++;
        chk("post_rst_cfg_clear", 32'(nz), 32'd0);

        // Decoder usable after reset
        c = rsp_seen;
        push_rsp(32'h0, 1'b0);
        send_req(mk(7'h01, OPC), 32'd0, 32'h0000_0001);
        chk("post_rst_cfg0", config_reg0[0], 32'h1);
        wait_rsp(c + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nice_inst_decoder.md
Name: nice_inst_decoder

Overview:
Custom-0 instruction decoder and sequencer for the E203 NICE coprocessor port. It accepts NICE requests and handles three classes of work:
- configuration-register writes and reads;
- memory loads over ICB, streamed out to the command FIFO;
- memory stores over ICB, fed from the response width converter.
It sits between the core's NICE/ICB interfaces and the custom-0 accelerator datapath. Each request gets exactly one NICE response.

Parameters:
- INPUT_DATA_WIDTH, 32: rs1/rs2, ICB rdata and id_rsp_rdata0 width.
- INPUT_INST_WIDTH, 32: instruction width.
- OUTPUT_DATA_WIDTH, 32: rsp_rdat, ICB wdata, id_cmd_wdata0 and config_reg0 entry width.
- OUTPUT_ADDR_WIDTH, 32: ICB address width.
- CONFIG_ENTRY0, 32: number of config registers.
- FETCH_MEM_WORD0, 4: words read per MEM_LD.
- WRITE_MEM_WORD0, 4: words written per MEM_ST.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- nice_active  out  1  block busy (state != IDLE).
- nice_req_valid / nice_req_ready  in / out  1 / 1  request handshake.
- nice_req_inst  in  INPUT_INST_WIDTH  instruction word.
- nice_req_rs1, nice_req_rs2  in  INPUT_DATA_WIDTH  operands.
- nice_rsp_valid / nice_rsp_ready  out / in  1 / 1  response handshake.
- nice_rsp_rdat  out  OUTPUT_DATA_WIDTH  result.
- nice_rsp_err  out  1  error flag.
- nice_icb_cmd_valid / nice_icb_cmd_ready  out / in  1 / 1  ICB command handshake.
- nice_icb_cmd_addr  out  OUTPUT_ADDR_WIDTH  ICB address.
- nice_icb_cmd_read  out  1  ICB read (1) / write (0).
- nice_icb_cmd_wdata  out  OUTPUT_DATA_WIDTH  ICB write data.
- nice_icb_cmd_size  out  2  ICB access size.
- nice_mem_holdup  out  1  high while a memory operation is in flight.
- nice_icb_rsp_valid / nice_icb_rsp_ready  in / out  1 / 1  ICB response handshake.
- nice_icb_rsp_rdata  in  INPUT_DATA_WIDTH  ICB read data.
- nice_icb_rsp_err  in  1  ICB error.
- id_cmd_valid0 / id_cmd_ready0  out / in  1 / 1  command FIFO push handshake.
- id_cmd_wdata0  out  OUTPUT_DATA_WIDTH  command FIFO data.
- id_rsp_valid0 / id_rsp_ready0  in / out  1 / 1  response width-converter pop handshake.
- id_rsp_rdata0  in  INPUT_DATA_WIDTH  response width-converter data.
- config_reg0  out  CONFIG_ENTRY0 x OUTPUT_DATA_WIDTH  configuration register file.

Behaviour:
- Instruction fields:
  - opcode = inst[6:0]; custom-0 is 7'b0001011.
  - funct7 = inst[31:25].
  - idx = rs1[$clog2(CONFIG_ENTRY0)-1:0].
- States: IDLE, LD, ST, RSP.
- nice_req_ready is asserted combinationally only in IDLE. A request is accepted when valid && ready.
- Decode on accept:
  - funct7 7'h01, CFG_WR: config_reg0[idx] <= rs2 on the accept edge. Go to RSP with rdat = 0, err = 0.
  - funct7 7'h03, MEM_LD: addr <= rs1, counters cleared, go to LD.
  - funct7 7'h04, MEM_ST: addr <= rs1, counters cleared, go to ST.
  - Any other opcode or funct7: go to RSP with rdat = 0, err = 1. No side effects.
  - If rs1 >= CONFIG_ENTRY0 on a CFG op: err = 1 and no write.
- ICB rules:
  - nice_icb_cmd_size is always 2'b10.
  - At most one command outstanding at a time.
  - Word k is at address addr + 4*k.
- LD state:
  - cmd_valid = !outstanding && issued < FETCH_MEM_WORD0; read = 1.
  - Read responses pass through combinationally to the command FIFO: id_cmd_valid0 = icb_rsp_valid, icb_rsp_ready = id_cmd_ready0, id_cmd_wdata0 = rdata.
  - A response counts only when accepted.
- ST state:
  - cmd_valid = !outstanding && issued < WRITE_MEM_WORD0 && id_rsp_valid0; read = 0; wdata = id_rsp_rdata0.
  - id_rsp_ready0 = the same conditions && nice_icb_cmd_ready, so exactly one pop per command handshake.
  - icb_rsp_ready = 1.
- Completion: when the responses received equal N, go to RSP with rdat = 0. err is the OR of all nice_icb_rsp_err seen (sticky).
- RSP state: nice_rsp_valid = 1, rdat and err held stable until nice_rsp_ready; then go to IDLE. A new request can be accepted the cycle after the response handshake.
- nice_mem_holdup = (state == LD || state == ST). nice_active = (state != IDLE).
- Outside LD/ST, every ICB and id_* valid/ready output is 0.
- Reset, including mid-operation: abort to IDLE; clear counters, outstanding flag and rsp regs; config_reg0 all 0. An in-flight ICB transaction is dropped.
- Stalls: id_rsp_valid0 low in ST or id_cmd_ready0 low in LD stall the sequence indefinitely. Nothing is lost and addresses do not advance.

Optional Feature:
- NICE_CFG_RD_EN defined: funct7 7'h02 (CFG_RD) is legal and returns rdat = config_reg0[idx], err = 0 (err = 1 and rdat = 0 when out of range). It is a single-cycle transition to RSP.
- NICE_CFG_RD_EN undefined: funct7 7'h02 decodes as illegal (err = 1).

Decomposition:
- Package nice_dec_pkg holds:
  - OPC_CUSTOM0;
  - the funct7 codes F7_CFG_WR, F7_CFG_RD, F7_MEM_LD, F7_MEM_ST;
  - ICB_SIZE_WORD;
  - the state_e enum.
- One natural sub-module, nice_icb_seq: the address/issue/response counter and single-outstanding tracker, shared by LD and ST, parameterised by word count.

Test Plan:
- CFG_WR, inst funct7 = 7'h01, rs1 = 5, rs2 = 32'h12345678 -> config_reg0[5] = 32'h12345678 after accept; one rsp with err = 0, rdat = 0.
- MEM_LD, rs1 = 32'h8000_0000, memory words AAAAAAAA/BBBBBBBB/CCCCCCCC/DDDDDDDD, id_cmd_ready0 toggled 0/1 every 2 cycles -> 4 reads at 8000_0000..8000_000C, id_cmd_wdata0 carries the 4 words in order, then one rsp.
- MEM_ST, rs1 = 32'h9000_0000, id_rsp_valid0 pulses AAAAAAAA, gap, BBBBBBBB, gap, CCCCCCCC, DDDDDDDD -> 4 ICB writes with matching wdata at 9000_0000..9000_000C; id_rsp_ready0 asserted exactly 4 times.
- Opcode 7'b0101011 or funct7 = 7'h7F -> rsp err = 1, no ICB or config activity; nice_rsp_ready held low 5 cycles -> rsp_valid/rdat/err stable throughout.
- nice_icb_rsp_err = 1 on word 2 of MEM_LD -> all 4 words still processed, final rsp err = 1.
- rst asserted mid-MEM_ST after 2 words -> immediate IDLE, req_ready = 1 and nice_mem_holdup = 0 once rst deasserts, config regs 0.
